uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding per-requester byte FIFOs into one UART transmitter.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                             clk_16mhz,
  input  logic                                             rstn,
  input  logic [NUM_REQ-1:0]                               req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                    req_data,
  output logic [NUM_REQ-1:0]                               req_ready,
  output logic [DATA_WIDTH-1:0]                            tx_data,
  output logic                                             tx_en,
  input  logic                                             tx_done,
  output logic                                             busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                             timeout_err,
  input  logic                                             err_clr
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [NUM_REQ][FIFO_DEPTH];
  logic [PW-1:0]         wptr [NUM_REQ];
  logic [PW-1:0]         rptr [NUM_REQ];
  logic [CW-1:0]         cnt [NUM_REQ];
  logic [NUM_REQ-1:0]    push;
  logic [NUM_REQ-1:0]    pop;
  logic [GW-1:0]         sel;
  logic [GW-1:0]         last_grant;
  logic                  any;
  logic [TW-1:0]         tcnt;
  int                    best;

  // Winner is the non-empty FIFO closest after last_grant in circular order.
  always_comb begin
    best = NUM_REQ;
    sel  = '0;
    any  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = cnt[i] != CW'(FIFO_DEPTH);
      push[i]      = req_valid[i] & req_ready[i];
      if (cnt[i] != '0 && (i + 2*NUM_REQ - 1 - int'(last_grant)) % NUM_REQ < best) begin
        best = (i + 2*NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
        sel  = GW'(i);
        any  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      pop[i] = state == IDLE && any && sel == GW'(i);
  end

  always_ff @(posedge clk_16mhz)
    for (int i = 0; i < NUM_REQ; i++)
      if (push[i]) mem[i][wptr[i]] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk_16mhz or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wptr[i] <= wptr[i] + PW'(push[i]);
        rptr[i] <= rptr[i] + PW'(pop[i]);
        cnt[i]  <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end

  // A timeout set is written after err_clr so the set wins.
  always_ff @(posedge clk_16mhz or negedge rstn)
    if (!rstn) begin
      state       <= IDLE;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      last_grant  <= GW'(NUM_REQ - 1);
      timeout_err <= 1'b0;
      tcnt        <= '0;
    end else begin
      tx_en <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: if (any) begin
          state      <= LAUNCH;
          tx_en      <= 1'b1;
          busy       <= 1'b1;
          tx_data    <= mem[sel][rptr[sel]];
          grant_id   <= sel;
          last_grant <= sel;
        end
        LAUNCH: begin
          state <= BUSY;
          tcnt  <= '0;
        end
        BUSY: if (tx_done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state       <= IDLE;
          busy        <= 1'b0;
          timeout_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a small transmitter model answering tx_en with tx_done.
module tb_uart_tx_arbiter;
  localparam int TO = 20;

  logic        clk_16mhz = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [0:0]  grant_id;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int total = 0, bad = 0, cyc = 0;
  int en_cnt = 0, done_cnt = 0, dcnt = 0, last_done = -1;
  bit auto_done = 1'b0;
  logic [7:0] log_data[$];
  int         log_gid[$];
  int         log_gap[$];

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk_16mhz(clk_16mhz), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: sample on the falling edge and run the transmitter model.
  task automatic tick();
    @(negedge clk_16mhz);
    cyc++;
    tx_done = 1'b0;
    if (tx_en) begin
      log_data.push_back(tx_data);
      log_gid.push_back(int'(grant_id));
      log_gap.push_back(last_done < 0 ? -1 : cyc - last_done);
      en_cnt++;
      if (auto_done) dcnt = 11;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        tx_done = 1'b1;
        last_done = cyc;
        done_cnt++;
      end
    end
  endtask

  task automatic done_now();
    tx_done = 1'b1;
    last_done = cyc;
    done_cnt++;
    tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_valid = '0; req_data = '0; err_clr = 1'b0;
    tx_done = 1'b0; auto_done = 1'b0; dcnt = 0;
    tick(); tick();
    rstn = 1'b1;
    log_data.delete(); log_gid.delete(); log_gap.delete();
    en_cnt = 0; done_cnt = 0; last_done = -1;
  endtask

  task automatic wait_en(input int n);
    for (int i = 0; i < 100 && en_cnt < n; i++) tick();
    chk("wait_en", en_cnt, n);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 300 && done_cnt < n; i++) tick();
    chk("wait_done", done_cnt, n);
  endtask

  task automatic push1(input int r, input logic [7:0] d);
    req_valid = 2'(1 << r);
    req_data = {d, d};
    tick();
    req_valid = '0;
  endtask

  initial begin
    // basic transfer and reset values
    do_reset();
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_ready", req_ready, 2'b11);
    auto_done = 1'b1;
    push1(0, 8'hA5);
    wait_en(1);
    chk("t1_en", tx_en, 1);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_gid", grant_id, 0);
    tick();
    chk("t1_en_pulse", tx_en, 0);
    chk("t1_busy_on", busy, 1);
    wait_done(1);
    chk("t1_busy_still", busy, 1);
    tick();
    chk("t1_busy_off", busy, 0);
    chk("t1_en_cnt", en_cnt, 1);

    // round robin with back-to-back spacing
    do_reset();
    auto_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b11;
      req_data = {8'(32 + k), 8'(16 + k)};
      tick();
    end
    req_valid = '0;
    wait_done(6);
    chk("t2_n", log_data.size(), 6);
    for (int k = 0; k < 6 && k < log_data.size(); k++) begin
      chk($sformatf("t2_data%0d", k), log_data[k], (k % 2) ? 8'(32 + k/2) : 8'(16 + k/2));
      chk($sformatf("t2_gid%0d", k), log_gid[k], k % 2);
      if (k > 0) chk($sformatf("t2_gap%0d", k), log_gap[k], 2);
    end

    // full FIFO back-pressure, refuse push during pop, ordering
    do_reset();
    push1(0, 8'h01);
    wait_en(1);
    for (int k = 0; k < 5; k++) begin
      req_valid = 2'b10;
      req_data = {8'(8'h31 + k), 8'h00};
      chk($sformatf("t3_ready%0d", k), req_ready[1], k < 4);
      tick();
    end
    auto_done = 1'b1;
    done_now();
    chk("t3_full_pop", req_ready[1], 0);
    tick();
    chk("t3_ready_back", req_ready[1], 1);
    tick();
    req_valid = '0;
    wait_done(6);
    chk("t3_n", log_data.size(), 6);
    for (int k = 0; k < 6 && k < log_data.size(); k++) begin
      chk($sformatf("t3_data%0d", k), log_data[k], k == 0 ? 8'h01 : 8'(8'h30 + k));
      chk($sformatf("t3_gid%0d", k), log_gid[k], k == 0 ? 0 : 1);
    end

    // timeout, next byte launches, clear, set beats clear
    do_reset();
    req_valid = 2'b01;
    req_data = 16'h0041;
    tick();
    req_data = 16'h0042;
    tick();
    req_valid = '0;
    wait_en(1);
    repeat (TO) tick();
    chk("t4_err_early", timeout_err, 0);
    chk("t4_busy_early", busy, 1);
    tick();
    chk("t4_err_set", timeout_err, 1);
    chk("t4_busy_drop", busy, 0);
    tick();
    chk("t4_next_en", tx_en, 1);
    chk("t4_next_data", tx_data, 8'h42);
    err_clr = 1'b1;
    tick();
    chk("t4_err_clr", timeout_err, 0);
    repeat (TO - 1) tick();
    chk("t4_err_pre", timeout_err, 0);
    tick();
    chk("t4_set_wins", timeout_err, 1);
    err_clr = 1'b0;
    tick();
    chk("t4_err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr2", timeout_err, 0);

    // tx_done in the timeout cycle wins
    do_reset();
    push1(0, 8'h44);
    wait_en(1);
    repeat (TO) tick();
    done_now();
    chk("t4b_err", timeout_err, 0);
    chk("t4b_busy", busy, 0);

    // reset mid-transfer discards everything
    do_reset();
    push1(0, 8'h51);
    wait_en(1);
    req_valid = 2'b10;
    req_data = 16'h5200;
    tick();
    req_data = 16'h5300;
    tick();
    req_valid = '0;
    tick();
    chk("t5_busy_pre", busy, 1);
    rstn = 1'b0;
    #1;
    chk("t5_tx_en", tx_en, 0);
    chk("t5_tx_data", tx_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_gid", grant_id, 0);
    chk("t5_err", timeout_err, 0);
    chk("t5_ready", req_ready, 2'b11);
    tick();
    rstn = 1'b1;
    en_cnt = 0;
    repeat (30) tick();
    chk("t5_no_en", en_cnt, 0);
    chk("t5_idle", busy, 0);

    // tx_done ignored in IDLE and LAUNCH
    do_reset();
    done_now();
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_en", en_cnt, 0);
    push1(0, 8'h61);
    wait_en(1);
    done_now();
    chk("t6_launch_ign", busy, 1);
    repeat (3) tick();
    chk("t6_busy_hold", busy, 1);
    done_now();
    chk("t6_done", busy, 0);
    chk("t6_n", log_data.size(), 1);
    if (log_data.size() > 0) chk("t6_data", log_data[0], 8'h61);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
